// File: rtl/dat_mem_mover.sv
// ============================================================================
//  Module      : dat_mem_mover
//  Description : Block COPY / FILL / COMPARE engine driving a single-port
//                data memory. Optional checksum output: DAT_MEM_MOVER_CSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dat_mem_mover #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mismatch,
    output logic [AW-1:0] fail_idx,
`ifdef DAT_MEM_MOVER_CSUM_EN
    output logic [DW-1:0] csum,
`endif
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_rd_a = 3'd1;
    localparam logic [2:0] c_wr   = 3'd2;
    localparam logic [2:0] c_rd_b = 3'd3;
    localparam logic [2:0] c_fill = 3'd4;
    localparam logic [2:0] c_done = 3'd5;

    localparam logic [1:0] c_op_copy = 2'b00;
    localparam logic [1:0] c_op_fill = 2'b01;
    localparam logic [1:0] c_op_cmp  = 2'b10;
    localparam logic [AW:0] c_one    = 1;

    logic [2:0]    r_state;
    logic [1:0]    r_op;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW:0]   r_count;
    logic [AW:0]   r_idx;
    logic [DW-1:0] r_buf;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_mismatch;
    logic [AW-1:0] r_fail_idx;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_wr_en;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_csum;

    logic [AW:0]   w_idx_inc;
    logic [AW-1:0] w_src_nxt;
    logic [AW-1:0] w_dst_nxt;
    logic [AW-1:0] w_dst_cur;
    logic          w_last;

    assign w_idx_inc = r_idx + 1'b1;
    assign w_src_nxt = r_src + w_idx_inc[AW-1:0];
    assign w_dst_nxt = r_dst + w_idx_inc[AW-1:0];
    assign w_dst_cur = r_dst + r_idx[AW-1:0];
    assign w_last    = (r_count == c_one);

    // Memory outputs are registered for the state being entered, so each
    // write holds address/data for a full cycle across the negedge commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_op        <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_buf       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mismatch  <= 1'b0;
            r_fail_idx  <= '0;
            r_mem_addr  <= '0;
            r_mem_wr_en <= 1'b0;
            r_mem_wdata <= '0;
            r_csum      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_op       <= op;
                        r_src      <= src;
                        r_dst      <= dst;
                        r_count    <= {(len == '0), len};
                        r_idx      <= '0;
                        r_err      <= 1'b0;
                        r_mismatch <= 1'b0;
                        r_fail_idx <= '0;
                        r_csum     <= '0;
                        case (op)
                            c_op_copy, c_op_cmp: begin
                                r_state    <= c_rd_a;
                                r_busy     <= 1'b1;
                                r_mem_addr <= src;
                            end
                            c_op_fill: begin
                                r_state     <= c_fill;
                                r_busy      <= 1'b1;
                                r_mem_addr  <= dst;
                                r_mem_wdata <= fill_val;
                                r_mem_wr_en <= 1'b1;
                            end
                            default: begin
                                r_state <= c_done;
                                r_err   <= 1'b1;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                c_rd_a: begin
                    r_buf      <= mem_rdata;
                    r_mem_addr <= w_dst_cur;
                    if (r_op == c_op_copy) begin
                        r_state     <= c_wr;
                        r_mem_wdata <= mem_rdata;
                        r_mem_wr_en <= 1'b1;
                    end else begin
                        r_state <= c_rd_b;
                        r_csum  <= r_csum + mem_rdata;
                    end
                end
                c_wr, c_rd_b, c_fill: begin
                    if (r_state != c_rd_b) begin
                        r_csum <= r_csum + r_mem_wdata;
                    end
                    if (r_state == c_rd_b && mem_rdata != r_buf) begin
                        r_mismatch <= 1'b1;
                        r_fail_idx <= r_idx[AW-1:0];
                    end else begin
                        r_idx   <= w_idx_inc;
                        r_count <= r_count - 1'b1;
                    end
                    if (w_last || (r_state == c_rd_b && mem_rdata != r_buf)) begin
                        r_state     <= c_done;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_mem_addr  <= '0;
                        r_mem_wr_en <= 1'b0;
                        r_mem_wdata <= '0;
                    end else if (r_state == c_fill) begin
                        r_mem_addr <= w_dst_nxt;
                    end else begin
                        r_state     <= c_rd_a;
                        r_mem_addr  <= w_src_nxt;
                        r_mem_wr_en <= 1'b0;
                        r_mem_wdata <= '0;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state     <= c_idle;
                    r_busy      <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wr_en <= 1'b0;
                    r_mem_wdata <= '0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign mismatch  = r_mismatch;
    assign fail_idx  = r_fail_idx;
    assign mem_addr  = r_mem_addr;
    assign mem_wr_en = r_mem_wr_en;
    assign mem_wdata = r_mem_wdata;

`ifdef DAT_MEM_MOVER_CSUM_EN
    assign csum = r_csum;
`else
    logic w_csum_unused;
    assign w_csum_unused = ^r_csum;
`endif

endmodule

`default_nettype wire
